// File: rtl/afe_pkg.sv
// Shared types and defaults for the dual-slope AFE behavioural model.
// Used by afe_behav_model and afe_sat_acc.
package afe_pkg;

    typedef enum logic [1:0] {
        AFE_IDLE  = 2'b00,
        AFE_AZ    = 2'b01,
        AFE_INT   = 2'b10,
        AFE_DEINT = 2'b11
    } afe_sel_e;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_REF_TEST   = 2'b01,
        MODE_ZERO       = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } mode_sel_e;

    typedef enum logic [1:0] {
        DBG_COMP    = 2'b00,
        DBG_REF_OK  = 2'b01,
        DBG_INT_MSB = 2'b10,
        DBG_SAT     = 2'b11
    } dbg_sel_e;

    localparam int DEF_REF_SETTLE = 1000;
    localparam int DEF_AZ_SHIFT   = 4;

endpackage

// File: rtl/afe_sat_acc.sv
// Signed saturating accumulator with symmetric clamp and sticky clamp flags.
// acc_next is exported so the parent can register decisions on the next value.
module afe_sat_acc
    import afe_pkg::*;
#(
    parameter int W     = 24,
    parameter int LIMIT = 2 ** (W - 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic signed [W:0]   inc,
    output logic signed [W-1:0] acc,
    output logic signed [W-1:0] acc_next,
    output logic                sat_hi,
    output logic                sat_lo
);

    localparam logic signed [W:0]   LIM_X   = (W + 1)'(LIMIT);
    localparam logic signed [W-1:0] LIM     = LIM_X[W-1:0];
    localparam logic signed [W-1:0] NEG_LIM = -LIM;

    logic signed [W:0] acc_x;
    logic signed [W:0] sum;
    logic              hi_next;
    logic              lo_next;

    // One guard bit keeps the sum exact before the clamp decision.
    assign acc_x = {acc[W-1], acc};
    assign sum   = acc_x + inc;

    always_comb begin
        acc_next = acc;
        hi_next  = sat_hi;
        lo_next  = sat_lo;
        if (clr) begin
            acc_next = '0;
            hi_next  = 1'b0;
            lo_next  = 1'b0;
        end else if (en) begin
            if (sum > LIM_X) begin
                acc_next = LIM;
                hi_next  = 1'b1;
            end else if (sum < -LIM_X) begin
                acc_next = NEG_LIM;
                lo_next  = 1'b1;
            end else begin
                acc_next = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else begin
            acc    <= acc_next;
            sat_hi <= hi_next;
            sat_lo <= lo_next;
        end
    end

endmodule

// File: rtl/afe_behav_model.sv
// Cycle-based behavioural model of the dual-slope AFE: settle counter, input mux,
// integrator, comparator and debug mux. AFE_MODEL_NOISE_EN adds LFSR dither.
module afe_behav_model
    import afe_pkg::*;
#(
    parameter int VIN_W      = 16,
    parameter int INT_W      = 24,
    parameter int SAT_LIMIT  = 2 ** (INT_W - 2),
    parameter int REF_SETTLE = DEF_REF_SETTLE,
    parameter int AZ_SHIFT   = DEF_AZ_SHIFT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [VIN_W-1:0] vin_code_i,
    input  logic [VIN_W-2:0]        vref_code_i,
    input  logic [1:0]              afe_sel_i,
    input  logic [2:0]              range_sel_i,
    input  logic                    afe_reset_i,
    input  logic                    ref_sign_i,
    input  logic [1:0]              mode_sel_i,
    output logic                    comp_o,
    output logic                    sat_hi_o,
    output logic                    sat_lo_o,
    output logic                    ref_ok_o,
    output logic [INT_W-1:0]        int_mon_o,
    output logic                    analog_test_o,
    input  logic [7:0]              dbg_i
);

    localparam int                    CNT_W      = $clog2(REF_SETTLE + 1);
    localparam logic [CNT_W-1:0]      SETTLE_MAX = CNT_W'(REF_SETTLE);
    localparam logic signed [INT_W-1:0] AZ_THR   = INT_W'(1 << AZ_SHIFT);

    logic [CNT_W-1:0]        settle_cnt;
    logic [CNT_W-1:0]        settle_next;
    logic signed [INT_W-1:0] acc;
    logic signed [INT_W-1:0] acc_next;
    logic signed [INT_W:0]   acc_x;
    logic signed [INT_W-1:0] vin_ext;
    logic signed [INT_W-1:0] eff_in;
    logic signed [INT_W:0]   eff_x;
    logic signed [INT_W:0]   vref_x;
    logic signed [INT_W:0]   noise;
    logic signed [INT_W:0]   inc;
    logic                    acc_en;
    logic                    unused_dbg;

    assign settle_next = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            settle_cnt <= '0;
            ref_ok_o   <= 1'b0;
            comp_o     <= 1'b0;
        end else begin
            settle_cnt <= settle_next;
            ref_ok_o   <= (settle_next == SETTLE_MAX);
            comp_o     <= !acc_next[INT_W-1] && (acc_next != '0);
        end
    end

`ifdef AFE_MODEL_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Dither in -4..+3, applied to every integrate/de-integrate increment.
    assign noise = $signed({{(INT_W - 2){1'b0}}, lfsr[2:0]}) - (INT_W + 1)'(4);
`else
    assign noise = '0;
`endif

    assign vin_ext = {{(INT_W - VIN_W){vin_code_i[VIN_W-1]}}, vin_code_i};
    assign vref_x  = {{(INT_W - VIN_W + 2){1'b0}}, vref_code_i};
    assign eff_x   = {eff_in[INT_W-1], eff_in};
    assign acc_x   = {acc[INT_W-1], acc};

    always_comb begin
        eff_in = vin_ext <<< range_sel_i;
        case (mode_sel_e'(mode_sel_i))
            MODE_REF_TEST: eff_in = vref_x[INT_W-1:0];
            MODE_ZERO:     eff_in = '0;
            default:       ;
        endcase
    end

    // Increment handed to the saturating accumulator; nothing moves until settled.
    always_comb begin
        inc    = '0;
        acc_en = 1'b0;
        if (ref_ok_o) begin
            case (afe_sel_e'(afe_sel_i))
                AFE_AZ: begin
                    acc_en = 1'b1;
                    inc    = (acc < AZ_THR && acc > -AZ_THR) ? -acc_x : -(acc_x >>> AZ_SHIFT);
                end
                AFE_INT: begin
                    acc_en = 1'b1;
                    inc    = eff_x + noise;
                end
                AFE_DEINT: begin
                    acc_en = 1'b1;
                    inc    = (ref_sign_i ? vref_x : -vref_x) + noise;
                end
                default: ;
            endcase
        end
    end

    afe_sat_acc #(
        .W     (INT_W),
        .LIMIT (SAT_LIMIT)
    ) u_sat_acc (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (afe_reset_i),
        .en       (acc_en),
        .inc      (inc),
        .acc      (acc),
        .acc_next (acc_next),
        .sat_hi   (sat_hi_o),
        .sat_lo   (sat_lo_o)
    );

    assign int_mon_o  = acc;
    assign unused_dbg = ^dbg_i[7:2];

    always_comb begin
        analog_test_o = comp_o;
        case (dbg_sel_e'(dbg_i[1:0]))
            DBG_COMP:    analog_test_o = comp_o;
            DBG_REF_OK:  analog_test_o = ref_ok_o;
            DBG_INT_MSB: analog_test_o = int_mon_o[INT_W-1];
            DBG_SAT:     analog_test_o = sat_hi_o | sat_lo_o;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_afe_behav_model.sv
// Self-checking bench for afe_behav_model (default parameters, noise disabled).
// A cycle model pushes expected state per edge; each test pops and compares.
module tb_afe_behav_model;
    import afe_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] vin = '0;
    logic [14:0]        vref = '0;
    logic [1:0]         sel = 2'b00;
    logic [2:0]         range_sel = '0;
    logic               afe_reset = 1'b0;
    logic               ref_sign = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [7:0]         dbg = '0;
    logic               comp, sat_hi, sat_lo, ref_ok, analog_test;
    logic [23:0]        int_mon;

    afe_behav_model dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .vin_code_i    (vin),
        .vref_code_i   (vref),
        .afe_sel_i     (sel),
        .range_sel_i   (range_sel),
        .afe_reset_i   (afe_reset),
        .ref_sign_i    (ref_sign),
        .mode_sel_i    (mode),
        .comp_o        (comp),
        .sat_hi_o      (sat_hi),
        .sat_lo_o      (sat_lo),
        .ref_ok_o      (ref_ok),
        .int_mon_o     (int_mon),
        .analog_test_o (analog_test),
        .dbg_i         (dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint iv;
        bit     comp;
        bit     hi;
        bit     lo;
        bit     rok;
    } exp_t;

    localparam longint LIM = 4194304;

    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    longint m_int;
    bit     m_comp, m_hi, m_lo, m_rok;
    int     m_cnt;

    function automatic longint mon();
        return longint'($signed(int_mon));
    endfunction

    task automatic model_reset();
        m_int = 0; m_comp = 0; m_hi = 0; m_lo = 0; m_rok = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    // Model one rising edge from the currently driven inputs, then clock the DUT.
    task automatic step();
        longint inc, sum;
        exp_t   e;
        inc = 0;
        if (afe_reset) begin
            m_int = 0; m_hi = 0; m_lo = 0;
        end else if (m_rok && sel != 2'b00) begin
            case (sel)
                2'b01:   inc = (m_int > -16 && m_int < 16) ? -m_int : -(m_int >>> 4);
                2'b10:   inc = (mode == 2'b01) ? longint'(vref) :
                               (mode == 2'b10) ? 0 : (longint'(vin) <<< range_sel);
                default: inc = ref_sign ? longint'(vref) : -longint'(vref);
            endcase
            sum = m_int + inc;
            if (sum > LIM)       begin m_int = LIM;  m_hi = 1; end
            else if (sum < -LIM) begin m_int = -LIM; m_lo = 1; end
            else                 m_int = sum;
        end
        m_comp = (m_int > 0);
        if (m_cnt < 1000) m_cnt++;
        m_rok = (m_cnt == 1000);
        e.iv = m_int; e.comp = m_comp; e.hi = m_hi; e.lo = m_lo; e.rok = m_rok;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        tests++;
        if (int_mon !== 24'd0) begin fails++; $display("FAIL reset_int: got %0d want 0", mon()); end
        tests++;
        if ({comp, sat_hi, sat_lo, ref_ok, analog_test} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 00000", {comp, sat_hi, sat_lo, ref_ok, analog_test});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_settle();
        exp_t e;
        sel = 2'b10; vin = 16'sd5;
        for (int i = 0; i < 1000; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (ref_ok !== e.rok) begin fails++; $display("FAIL settle_ref_ok edge %0d: got %b want %b", i + 1, ref_ok, e.rok); end
            tests++;
            if (mon() !== e.iv) begin fails++; $display("FAIL settle_frozen edge %0d: got %0d want %0d", i + 1, mon(), e.iv); end
        end
        sel = 2'b00;
    endtask

    task automatic test_integrate_deint();
        exp_t e;
        afe_reset = 1'b1; step(); void'(exp_q.pop_front()); afe_reset = 1'b0;
        sel = 2'b10; vin = 16'sd100; range_sel = 3'd0; mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv) begin fails++; $display("FAIL integ_step %0d: got %0d want %0d", i, mon(), e.iv); end
        end
        tests++;
        if (mon() !== 1000 || comp !== 1'b1) begin fails++; $display("FAIL integ_final: got %0d/%b want 1000/1", mon(), comp); end
        sel = 2'b11; vref = 15'd50; ref_sign = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (comp !== e.comp || mon() !== e.iv) begin
                fails++; $display("FAIL deint_step %0d: got %0d/%b want %0d/%b", i + 1, mon(), comp, e.iv, e.comp);
            end
        end
        tests++;
        if (mon() !== 0 || comp !== 1'b0) begin fails++; $display("FAIL deint_final: got %0d/%b want 0/0", mon(), comp); end
        sel = 2'b00;
    endtask

    task automatic test_autozero();
        longint starts[3] = '{1600, 15, -1600};
        longint want[3]   = '{1500, 0, -1500};
        exp_t   e;
        for (int k = 0; k < 3; k++) begin
            afe_reset = 1'b1; sel = 2'b00; step(); void'(exp_q.pop_front()); afe_reset = 1'b0;
            sel = 2'b10; vin = 16'(starts[k]); range_sel = 3'd0; mode = 2'b00;
            step(); void'(exp_q.pop_front());
            sel = 2'b01;
            step();
            e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv || mon() !== want[k]) begin
                fails++; $display("FAIL autozero from %0d: got %0d want %0d", starts[k], mon(), want[k]);
            end
        end
        sel = 2'b00;
    endtask

    task automatic test_saturation();
        exp_t e;
        afe_reset = 1'b1; step(); void'(exp_q.pop_front()); afe_reset = 1'b0;
        sel = 2'b10; vin = 16'sd32767; range_sel = 3'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv || sat_hi !== e.hi) begin fails++; $display("FAIL sat_hi_step %0d: got %0d/%b want %0d/%b", i, mon(), sat_hi, e.iv, e.hi); end
        end
        tests++;
        if (mon() !== LIM || sat_hi !== 1'b1) begin fails++; $display("FAIL sat_hi_clamp: got %0d/%b want %0d/1", mon(), sat_hi, LIM); end
        sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (sat_hi !== e.hi) begin fails++; $display("FAIL sat_hi_sticky %0d: got %b want %b", i, sat_hi, e.hi); end
        end
        afe_reset = 1'b1; step(); e = exp_q.pop_front(); afe_reset = 1'b0;
        tests++;
        if (sat_hi !== e.hi || mon() !== e.iv) begin fails++; $display("FAIL sat_clear: got %0d/%b want %0d/%b", mon(), sat_hi, e.iv, e.hi); end
        // exactly -SAT_LIMIT is not a clamp; one more step is
        sel = 2'b10; vin = -16'sd32768;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv || sat_lo !== e.lo) begin fails++; $display("FAIL sat_lo_step %0d: got %0d/%b want %0d/%b", i, mon(), sat_lo, e.iv, e.lo); end
        end
        vin = 16'sd32767;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv || sat_hi !== e.hi || sat_lo !== e.lo) begin
                fails++; $display("FAIL sat_both_step %0d: got %0d/%b%b want %0d/%b%b", i, mon(), sat_hi, sat_lo, e.iv, e.hi, e.lo);
            end
        end
        tests++;
        if ({sat_hi, sat_lo} !== 2'b11) begin fails++; $display("FAIL sat_both_flags: got %b want 11", {sat_hi, sat_lo}); end
        sel = 2'b00; range_sel = 3'd0;
        afe_reset = 1'b1; step(); void'(exp_q.pop_front()); afe_reset = 1'b0;
    endtask

    task automatic test_modes();
        exp_t e;
        sel = 2'b10; vin = 16'sd100; afe_reset = 1'b1;
        step(); e = exp_q.pop_front(); afe_reset = 1'b0;
        tests++;
        if (mon() !== 0 || mon() !== e.iv) begin fails++; $display("FAIL reset_priority: got %0d want 0", mon()); end
        mode = 2'b01; vref = 15'd7;
        for (int i = 0; i < 3; i++) begin
            step(); e = exp_q.pop_front();
            tests++;
            if (mon() !== e.iv) begin fails++; $display("FAIL ref_test_step %0d: got %0d want %0d", i, mon(), e.iv); end
        end
        tests++;
        if (mon() !== 21) begin fails++; $display("FAIL ref_test_final: got %0d want 21", mon()); end
        mode = 2'b10;
        for (int i = 0; i < 2; i++) begin
            step(); e = exp_q.pop_front();
            tests++;
            if (mon() !== 21 || mon() !== e.iv) begin fails++; $display("FAIL zero_mode_hold %0d: got %0d want 21", i, mon()); end
        end
        mode = 2'b11; vin = 16'sd3; range_sel = 3'd2;
        step(); e = exp_q.pop_front();
        tests++;
        if (mon() !== e.iv) begin fails++; $display("FAIL mode11_range: got %0d want %0d", mon(), e.iv); end
        mode = 2'b00; sel = 2'b11; ref_sign = 1'b1; vref = 15'd7; range_sel = 3'd0;
        step(); e = exp_q.pop_front();
        tests++;
        if (mon() !== e.iv) begin fails++; $display("FAIL deint_add: got %0d want %0d", mon(), e.iv); end
        sel = 2'b00; ref_sign = 1'b0;
    endtask

    task automatic test_debug_async_reset();
        logic [7:0] dsel[5] = '{8'h02, 8'h00, 8'h01, 8'h03, 8'hFE};
        exp_t e;
        bit   want;
        afe_reset = 1'b1; step(); void'(exp_q.pop_front()); afe_reset = 1'b0;
        sel = 2'b10; vin = -16'sd50;
        step(); e = exp_q.pop_front();
        tests++;
        if (mon() !== e.iv) begin fails++; $display("FAIL dbg_setup: got %0d want %0d", mon(), e.iv); end
        sel = 2'b00;
        for (int k = 0; k < 5; k++) begin
            dbg = dsel[k];
            #1;
            case (dsel[k][1:0])
                2'b00:   want = m_comp;
                2'b01:   want = m_rok;
                2'b10:   want = (m_int < 0);
                default: want = m_hi | m_lo;
            endcase
            tests++;
            if (analog_test !== want) begin fails++; $display("FAIL dbg_mux sel %h: got %b want %b", dsel[k], analog_test, want); end
        end
        dbg = 8'h01;
        sel = 2'b10; vin = 16'sd100;
        step(); void'(exp_q.pop_front());
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        tests++;
        if (int_mon !== 24'd0) begin fails++; $display("FAIL async_rst_int: got %0d want 0", mon()); end
        tests++;
        if ({comp, sat_hi, sat_lo, ref_ok, analog_test} !== 5'b0) begin
            fails++; $display("FAIL async_rst_flags: got %b want 00000", {comp, sat_hi, sat_lo, ref_ok, analog_test});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); e = exp_q.pop_front();
            tests++;
            if (ref_ok !== e.rok || mon() !== e.iv) begin
                fails++; $display("FAIL restart_settle %0d: got %b/%0d want %b/%0d", i, ref_ok, mon(), e.rok, e.iv);
            end
        end
        sel = 2'b00;
    endtask

    initial begin
        test_reset();
        test_settle();
        test_integrate_deint();
        test_autozero();
        test_saturation();
        test_modes();
        test_debug_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
